// File: rtl/counter_stream_checker.sv
// counter_stream_checker
// Link/integrity monitor for counter-driven test chains. Locks onto an
// increment-by-one stream, pulses o_mismatch on every discontinuity seen
// while locked and keeps a saturating error tally.
// Optional feature macro: CHK_WRAP_CNT_EN adds o_wrap_count, a count of
// all-ones-to-zero transitions matched while locked.
module counter_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sample_valid,
    input  logic [WIDTH-1:0]     i_sample_data,
    input  logic                 i_clear_err,
    output logic                 o_locked,
    output logic                 o_mismatch,
    output logic [ERR_WIDTH-1:0] o_err_count,
    output logic [WIDTH-1:0]     o_expected,
    output logic [1:0]           o_state
`ifdef CHK_WRAP_CNT_EN
    ,
    output logic [WIDTH-1:0]     o_wrap_count
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX     = {ERR_WIDTH{1'b1}};

    state_t               r_state;
    logic [3:0]           r_goodCnt;
    logic [ERR_WIDTH-1:0] r_errCount;
    logic [WIDTH-1:0]     r_expected;
    logic                 r_mismatch;
    logic                 r_locked;

    state_t               w_stateNext;
    logic [3:0]           w_goodNext;
    logic [3:0]           w_goodInc;
    logic [ERR_WIDTH-1:0] w_errNext;
    logic [WIDTH-1:0]     w_expectedNext;
    logic                 w_mismatchNext;
    logic                 w_countErr;
    logic                 w_match;

    // r_expected always holds prev + 1, so comparing against it is the
    // same as checking sample == prev + 1 with natural mod-2^WIDTH wrap.
    assign w_match   = (i_sample_data == r_expected);
    assign w_goodInc = r_goodCnt + 4'd1;

    // Next-state and next-value logic for the lock FSM and its counters.
    always_comb begin
        w_stateNext    = r_state;
        w_goodNext     = r_goodCnt;
        w_mismatchNext = 1'b0;
        w_countErr     = 1'b0;
        w_errNext      = r_errCount;
        w_expectedNext = r_expected;

        case (r_state)
            SEARCH: begin
                if (i_sample_valid) begin
                    w_stateNext = ACQUIRE;
                    w_goodNext  = 4'd0;
                end
            end
            ACQUIRE: begin
                if (i_sample_valid) begin
                    if (w_match) begin
                        if (w_goodInc == LOCK_TARGET) begin
                            w_stateNext = LOCKED;
                            w_goodNext  = 4'd0;
                        end else begin
                            w_goodNext = w_goodInc;
                        end
                    end else begin
                        w_goodNext = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (i_sample_valid && !w_match) begin
                    w_mismatchNext = 1'b1;
                    w_countErr     = 1'b1;
                    w_goodNext     = 4'd0;
                    w_stateNext    = ACQUIRE;
                end
            end
            default: begin
                w_stateNext = SEARCH;
            end
        endcase

        if (i_sample_valid) begin
            w_expectedNext = i_sample_data + WIDTH'(1);
        end

        if (i_clear_err) begin
            w_errNext = '0;
        end else if (w_countErr && (r_errCount != ERR_MAX)) begin
            w_errNext = r_errCount + ERR_WIDTH'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath registers; locked is decoded from the next state so it is
    // registered and drops in the same cycle the mismatch pulse appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_goodCnt  <= 4'd0;
            r_errCount <= '0;
            r_expected <= WIDTH'(1);
            r_mismatch <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_goodCnt  <= w_goodNext;
            r_errCount <= w_errNext;
            r_expected <= w_expectedNext;
            r_mismatch <= w_mismatchNext;
            r_locked   <= (w_stateNext == LOCKED);
        end
    end

`ifdef CHK_WRAP_CNT_EN
    logic [WIDTH-1:0] r_wrapCount;

    // Count matched all-ones-to-zero transitions taken while locked; a
    // matched sample of zero implies the previous value was all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrapCount <= '0;
        end else if (i_clear_err) begin
            r_wrapCount <= '0;
        end else if ((r_state == LOCKED) && i_sample_valid && w_match &&
                     (i_sample_data == '0)) begin
            r_wrapCount <= r_wrapCount + WIDTH'(1);
        end
    end

    assign o_wrap_count = r_wrapCount;
`endif

    assign o_locked    = r_locked;
    assign o_mismatch  = r_mismatch;
    assign o_err_count = r_errCount;
    assign o_expected  = r_expected;
    assign o_state     = r_state;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Self-checking bench for counter_stream_checker (LOCK_COUNT = 4).
// Build with +define+CHK_WRAP_CNT_EN to also check o_wrap_count.
module tb_counter_stream_checker;

   localparam logic [1:0] ST_SEARCH  = 2'b00;
   localparam logic [1:0] ST_ACQUIRE = 2'b01;
   localparam logic [1:0] ST_LOCKED  = 2'b10;

   logic       clk;
   logic       rst;
   logic       sampleValid;
   logic [7:0] sampleData;
   logic       clearErr;
   logic       locked;
   logic       mismatch;
   logic [7:0] errCount;
   logic [7:0] expectedVal;
   logic [1:0] state;
`ifdef CHK_WRAP_CNT_EN
   logic [7:0] wrapCount;
`endif

   typedef struct {
      string      tag;
      logic       locked;
      logic       mismatch;
      logic [7:0] err;
      logic [7:0] expv;
      logic [1:0] state;
      logic [7:0] wrap;
   } expect_t;

   expect_t scoreboard[$];

   int testsRun  = 0;
   int failCount = 0;
   logic [7:0] expWrap = 8'd0;

   counter_stream_checker #(
      .WIDTH(8),
      .LOCK_COUNT(4),
      .ERR_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_sample_valid(sampleValid),
      .i_sample_data(sampleData),
      .i_clear_err(clearErr),
      .o_locked(locked),
      .o_mismatch(mismatch),
      .o_err_count(errCount),
      .o_expected(expectedVal),
      .o_state(state)
`ifdef CHK_WRAP_CNT_EN
      ,
      .o_wrap_count(wrapCount)
`endif
   );

   // Free-running 100 MHz-style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed field against its required value.
   task automatic checkField(input string tag, input string field,
                             input logic [7:0] obs, input logic [7:0] req);
      testsRun++;
      assert (obs === req) else begin
         failCount++;
         $error("[TB] FAIL %s.%s observed=%h required=%h", tag, field, obs, req);
      end
   endtask

   // Push the expected result for the transaction just driven.
   task automatic pushExpect(input string tag, input logic eLocked, input logic eMis,
                             input logic [7:0] eErr, input logic [7:0] eExp,
                             input logic [1:0] eSt);
      expect_t e;
      e.tag      = tag;
      e.locked   = eLocked;
      e.mismatch = eMis;
      e.err      = eErr;
      e.expv     = eExp;
      e.state    = eSt;
      e.wrap     = expWrap;
      scoreboard.push_back(e);
   endtask

   // Pop the oldest expectation and compare every output against it.
   task automatic checkOutput();
      expect_t e;
      if (scoreboard.size() == 0) begin
         testsRun++;
         failCount++;
         $error("[TB] FAIL scoreboard observed=empty required=entry");
         return;
      end
      e = scoreboard.pop_front();
      checkField(e.tag, "locked",   {7'd0, locked},   {7'd0, e.locked});
      checkField(e.tag, "mismatch", {7'd0, mismatch}, {7'd0, e.mismatch});
      checkField(e.tag, "err",      errCount,         e.err);
      checkField(e.tag, "expected", expectedVal,      e.expv);
      checkField(e.tag, "state",    {6'd0, state},    {6'd0, e.state});
`ifdef CHK_WRAP_CNT_EN
      checkField(e.tag, "wrap",     wrapCount,        e.wrap);
`endif
   endtask

   // Drive one cycle of stimulus on the falling edge, then check just after
   // the rising edge that captures it.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic clr,
                                input string tag, input logic eLocked, input logic eMis,
                                input logic [7:0] eErr, input logic [7:0] eExp,
                                input logic [1:0] eSt);
      @(negedge clk);
      sampleValid = v;
      sampleData  = d;
      clearErr    = clr;
      pushExpect(tag, eLocked, eMis, eErr, eExp, eSt);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Directed sequence following the test plan.
   initial begin
      logic [7:0] p;
      logic [7:0] d;
      logic [7:0] dd;
      logic [7:0] expErr;

      rst         = 1'b1;
      sampleValid = 1'b0;
      sampleData  = 8'h00;
      clearErr    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pushExpect("reset", 1'b0, 1'b0, 8'd0, 8'h01, ST_SEARCH);
      checkOutput();
      @(negedge clk);
      rst = 1'b0;

      // Initial acquisition and lock
      applyStimulus(1'b1, 8'h10, 1'b0, "search", 1'b0, 1'b0, 8'd0, 8'h11, ST_ACQUIRE);
      for (int i = 8'h11; i <= 8'h13; i++) begin
         d = 8'(i);
         applyStimulus(1'b1, d, 1'b0, "acquire", 1'b0, 1'b0, 8'd0, d + 8'd1, ST_ACQUIRE);
      end
      applyStimulus(1'b1, 8'h14, 1'b0, "lock", 1'b1, 1'b0, 8'd0, 8'h15, ST_LOCKED);
      for (int i = 8'h15; i <= 8'h20; i++) begin
         d = 8'(i);
         applyStimulus(1'b1, d, 1'b0, "locked_run", 1'b1, 1'b0, 8'd0, d + 8'd1, ST_LOCKED);
      end

      // Discontinuity while locked, then relock
      applyStimulus(1'b1, 8'h25, 1'b0, "locked_mismatch", 1'b0, 1'b1, 8'd1, 8'h26, ST_ACQUIRE);
      for (int i = 8'h26; i <= 8'h28; i++) begin
         d = 8'(i);
         applyStimulus(1'b1, d, 1'b0, "reacquire", 1'b0, 1'b0, 8'd1, d + 8'd1, ST_ACQUIRE);
      end
      applyStimulus(1'b1, 8'h29, 1'b0, "relock", 1'b1, 1'b0, 8'd1, 8'h2A, ST_LOCKED);
      applyStimulus(1'b0, 8'hAA, 1'b0, "idle_hold", 1'b1, 1'b0, 8'd1, 8'h2A, ST_LOCKED);

      // Run up to and across the 0xFF -> 0x00 wrap while locked
      for (int i = 8'h2A; i <= 8'hFF; i++) begin
         d = 8'(i);
         applyStimulus(1'b1, d, 1'b0, "to_wrap", 1'b1, 1'b0, 8'd1, d + 8'd1, ST_LOCKED);
      end
      expWrap = 8'd1;
      applyStimulus(1'b1, 8'h00, 1'b0, "wrap", 1'b1, 1'b0, 8'd1, 8'h01, ST_LOCKED);
      applyStimulus(1'b1, 8'h01, 1'b0, "post_wrap", 1'b1, 1'b0, 8'd1, 8'h02, ST_LOCKED);

      // Mismatches in ACQUIRE are silent and reset the good count
      applyStimulus(1'b1, 8'h05, 1'b0, "to_acquire", 1'b0, 1'b1, 8'd2, 8'h06, ST_ACQUIRE);
      applyStimulus(1'b1, 8'h09, 1'b0, "acq_silent1", 1'b0, 1'b0, 8'd2, 8'h0A, ST_ACQUIRE);
      applyStimulus(1'b1, 8'h03, 1'b0, "acq_silent2", 1'b0, 1'b0, 8'd2, 8'h04, ST_ACQUIRE);
      for (int i = 8'h04; i <= 8'h06; i++) begin
         d = 8'(i);
         applyStimulus(1'b1, d, 1'b0, "acq_partial", 1'b0, 1'b0, 8'd2, d + 8'd1, ST_ACQUIRE);
      end
      applyStimulus(1'b1, 8'h09, 1'b0, "acq_silent3", 1'b0, 1'b0, 8'd2, 8'h0A, ST_ACQUIRE);
      for (int i = 8'h0A; i <= 8'h0C; i++) begin
         d = 8'(i);
         applyStimulus(1'b1, d, 1'b0, "acq_restart", 1'b0, 1'b0, 8'd2, d + 8'd1, ST_ACQUIRE);
      end
      applyStimulus(1'b1, 8'h0D, 1'b0, "acq_lock", 1'b1, 1'b0, 8'd2, 8'h0E, ST_LOCKED);

      // Saturate the error counter with 260 locked-state mismatches
      p      = 8'h0D;
      expErr = 8'd2;
      for (int i = 0; i < 260; i++) begin
         d      = p + 8'd5;
         expErr = (expErr == 8'hFF) ? 8'hFF : expErr + 8'd1;
         applyStimulus(1'b1, d, 1'b0, "sat_mismatch", 1'b0, 1'b1, expErr, d + 8'd1, ST_ACQUIRE);
         for (int k = 1; k <= 4; k++) begin
            dd = d + 8'(k);
            applyStimulus(1'b1, dd, 1'b0, "sat_relock", k == 4, 1'b0, expErr, dd + 8'd1,
                          (k == 4) ? ST_LOCKED : ST_ACQUIRE);
         end
         p = d + 8'd4;
      end
      applyStimulus(1'b0, 8'h00, 1'b0, "sat_hold", 1'b1, 1'b0, 8'hFF, p + 8'd1, ST_LOCKED);

      // Clear coinciding with a counted mismatch: clear wins, pulse fires
      d       = p + 8'd7;
      expWrap = 8'd0;
      applyStimulus(1'b1, d, 1'b1, "clear_mismatch", 1'b0, 1'b1, 8'd0, d + 8'd1, ST_ACQUIRE);
      for (int k = 1; k <= 4; k++) begin
         dd = d + 8'(k);
         applyStimulus(1'b1, dd, 1'b0, "final_relock", k == 4, 1'b0, 8'd0, dd + 8'd1,
                       (k == 4) ? ST_LOCKED : ST_ACQUIRE);
      end
      applyStimulus(1'b0, 8'h77, 1'b0, "gap", 1'b1, 1'b0, 8'd0, dd + 8'd1, ST_LOCKED);

      // Asynchronous reset between clock edges while locked
      #2;
      rst = 1'b1;
      #1;
      expWrap = 8'd0;
      pushExpect("async_reset", 1'b0, 1'b0, 8'd0, 8'h01, ST_SEARCH);
      checkOutput();
      #1;
      rst = 1'b0;

      // First sample after release only loads prev
      applyStimulus(1'b1, 8'h50, 1'b0, "first_after_reset", 1'b0, 1'b0, 8'd0, 8'h51, ST_ACQUIRE);
      applyStimulus(1'b1, 8'h51, 1'b0, "second_after_reset", 1'b0, 1'b0, 8'd0, 8'h52, ST_ACQUIRE);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/counter_stream_checker.md
Name: counter_stream_checker

Overview:
Receive-side companion to the free-running 8-bit counter tile. It samples a counter value driven in from pins or another tile and locks onto the increment-by-one sequence. Once locked, it flags every discontinuity and keeps a saturating error tally. It sits between the pin inputs and the tile's output mux as a link/integrity monitor for counter-driven test chains.

Parameters:
WIDTH, 8, width of the observed counter value
LOCK_COUNT, 4, consecutive correct increments needed to declare lock (legal range 1..15)
ERR_WIDTH, 8, width of the saturating error counter

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
sample_valid  input  1  sample_data is valid this cycle
sample_data  input  WIDTH  observed counter value
clear_err  input  1  synchronous clear of err_count
locked  output  1  high while in LOCKED
mismatch  output  1  one-cycle pulse on a discontinuity detected while LOCKED
err_count  output  ERR_WIDTH  saturating count of LOCKED-state mismatches
expected  output  WIDTH  next value expected (prev + 1, mod 2^WIDTH)
state  output  2  current FSM state encoding, for debug

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state = SEARCH.
  - prev = 0; expected = 1.
  - good_cnt = 0; err_count = 0.
  - mismatch = 0; locked = 0.
- All outputs are registered. Effects of a valid sample appear the cycle after it is sampled.
- sample_valid low: all state holds; mismatch = 0.
- Match definition: sample_data == prev + 1, computed mod 2^WIDTH. Wrap from 0xFF to 0x00 is a match.
- On every valid sample, prev <= sample_data, whether it matched or not.
- FSM, encoding SEARCH=00, ACQUIRE=01, LOCKED=10, 11 illegal:
  - SEARCH: first valid sample loads prev, good_cnt <= 0, go to ACQUIRE. No compare is made.
  - ACQUIRE, match: good_cnt++. When the incremented value equals LOCK_COUNT, go to LOCKED and clear good_cnt.
  - ACQUIRE, mismatch: good_cnt <= 0, stay in ACQUIRE. No mismatch pulse, no err_count change.
  - LOCKED, match: stay in LOCKED.
  - LOCKED, mismatch: mismatch pulses high for exactly one cycle, err_count++ (saturating at all-ones), good_cnt <= 0, go to ACQUIRE.
  - Illegal state 11: next cycle goes to SEARCH.
- locked = (state == LOCKED). It drops the same cycle mismatch pulses.
- LOCK_COUNT = 1: a single correct increment after the first sample locks.
- Back-to-back mismatches: only the first one, taken while LOCKED, counts. Later mismatches in ACQUIRE are silent.
- clear_err: err_count <= 0 on the next edge. If it coincides with a counted mismatch, clear wins (err_count = 0) and the mismatch pulse still fires.
- err_count at all-ones stays all-ones on further mismatches until cleared.
- rst mid-operation: all registers go to reset values immediately, independent of clk.

Optional Feature:
CHK_WRAP_CNT_EN
- Defined: adds output port wrap_count [WIDTH-1:0], reset 0. It increments on every matched all-ones-to-zero transition taken while LOCKED, wraps mod 2^WIDTH, and is cleared by clear_err.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then valid samples 0x10,0x11,0x12,0x13,0x14 with LOCK_COUNT=4 -> locked rises the cycle after 0x14; expected = 0x15; err_count = 0.
- Locked at 0x20, then drive 0x25 -> mismatch is high one cycle, locked drops, err_count = 1, state = ACQUIRE. Continue 0x26..0x29 -> relock after 0x29.
- Locked, drive 0xFE,0xFF,0x00,0x01 -> no mismatch, stays locked. With CHK_WRAP_CNT_EN defined -> wrap_count = 1.
- In ACQUIRE, drive 0x05,0x09,0x03 -> no mismatch pulse, err_count unchanged, good_cnt resets each time.
- Force 260 LOCKED-state mismatches, relocking between each -> err_count holds 0xFF. clear_err asserted together with a mismatch -> err_count = 0 and mismatch pulses.
- Assert rst asynchronously while locked with sample_valid gaps present -> all outputs return to reset values before the next clk edge. First sample after release only loads prev.
